// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : load_store_unit                                        |
// | Brief   : byte-serial little-endian load/store memory initiator  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  count_q, count_d;
  logic [63:0] asm_q, asm_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;

  logic [64:0] w_req_span;
  logic [64:0] w_req_end;
  logic        w_range_err;
  logic [2:0]  w_last_idx;
  logic [63:0] w_asm_next;
  logic        w_xfer_next;

  function automatic logic [63:0] extend_load(input logic [63:0] v,
                                              input logic [1:0]  sz,
                                              input logic        uns);
    logic [63:0] r;
    r = v;
    case (sz)
      2'd0:    r = {{56{v[7]  & ~uns}}, v[7:0]};
      2'd1:    r = {{48{v[15] & ~uns}}, v[15:0]};
      2'd2:    r = {{32{v[31] & ~uns}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // 65-bit sum so a base near 2^64 that wraps is still seen as out of range
  assign w_req_span  = 65'd1 << req_size;
  assign w_req_end   = {1'b0, req_addr} + w_req_span;
  assign w_range_err = w_req_end > 65'(MEM_BYTES);

  always_comb begin
    w_last_idx = 3'd0;
    case (size_q)
      2'd0:    w_last_idx = 3'd0;
      2'd1:    w_last_idx = 3'd1;
      2'd2:    w_last_idx = 3'd3;
      default: w_last_idx = 3'd7;
    endcase
  end

  assign w_asm_next = asm_q | ({56'd0, mem_rdata} << {count_q, 3'b000});

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    count_d      = count_q;
    asm_d        = asm_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 64'd0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          count_d    = 3'd0;
          asm_d      = 64'd0;
          if (w_range_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (!write_q) begin
          asm_d = w_asm_next;
        end
        count_d = count_q + 3'd1;
        if (count_q == w_last_idx) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? 64'd0 : extend_load(w_asm_next, size_q, unsigned_q);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Memory strobes are registered from the upcoming state and byte index
    w_xfer_next = (state_d == ST_XFER);
    mem_addr_d  = w_xfer_next ? (addr_d + 64'(count_d)) : 64'd0;
    mem_re_d    = w_xfer_next && !write_d;
    mem_we_d    = w_xfer_next && write_d;
    mem_wdata_d = (w_xfer_next && write_d) ? wdata_d[{count_d, 3'b000} +: 8] : 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      count_q      <= 3'd0;
      asm_q        <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 8'd0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      count_q      <= count_d;
      asm_q        <= asm_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;

endmodule
`default_nettype wire
